dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port data memory: word address, 32-bit data, combinational read, write on the clock edge. Requester 0 is the core load/store unit and requester 1 is the DMA/debug loader. The block picks at most one access per cycle, round-robin on ties. It supports locked bursts with a starvation cap and returns read data registered, one cycle after the grant.

Parameters:
ADDR_W, 10, word address width driven to the memory
DATA_W, 32, data width
MAX_BURST, 8, max consecutive locked grants to one requester before forced release (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write (1) / read (0)
r0_lock  in  1  requester 0 asks to keep ownership after this access
r0_addr  in  ADDR_W  requester 0 word address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  access of requester 0 performed this cycle (combinational)
r0_rvalid  out  1  read data valid, one cycle after a read grant
r0_rdata  out  DATA_W  registered read data
r1_*  same seven signals for requester 1
mem_a  out  ADDR_W  memory address
mem_wd  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rd  in  DATA_W  memory combinational read data

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - state=IDLE, last=1 so r0 wins the first tie, burst_cnt=0.
  - rN_rvalid=0, rN_rdata=0.
  - A read granted in the reset cycle produces no rvalid.
- Grant rules: at most one rN_gnt high per cycle; gnt implies req. The access completes in the grant cycle; rN_req may change freely afterwards.
- Memory outputs:
  - With a grant: mem_a, mem_wd and mem_we are the winner's addr, wdata and we.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
- Read return: on a read grant, rN_rdata<=mem_rd and rN_rvalid<=1 at that edge. rvalid is a 1-cycle pulse. rdata holds its value until the next read for that requester. Writes never raise rvalid.
- IDLE state:
  - Only one req: grant it.
  - Both req: grant the requester != last.
  - On any grant: last<=winner.
  - If the winner has lock=1 and MAX_BURST>1: go to LOCKn with burst_cnt<=1. Otherwise stay IDLE.
- LOCKn state:
  - Only requester n may be granted; the other sees gnt=0 even if n is idle.
  - If req_n=1: grant n and burst_cnt<=burst_cnt+1. Return to IDLE if lock_n=0 or burst_cnt+1==MAX_BURST; otherwise stay in LOCKn.
  - If req_n=0: no grant this cycle, burst_cnt<=0, return to IDLE (one bubble cycle).
- Forced release: after exit from a full burst last=n, so a waiting other requester wins the next IDLE cycle. Worst-case wait for either requester is MAX_BURST+1 cycles.
- burst_cnt is width $clog2(MAX_BURST+1). It never exceeds MAX_BURST and is cleared on every return to IDLE.
- Address is not range-checked; it is passed through unchanged.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t
  - localparams REQ0=0, REQ1=1
  - default ADDR_W/DATA_W constants shared with the memory wrapper
- Optional sub-module dmem_arb_pick: combinational round-robin pick from req[1:0], last and state, producing a one-hot gnt.
- Everything else (FSM, counter, read-return registers) stays in dmem_arbiter.

Test Plan:
1. Reset then r0 write addr 5 data 0xDEADBEEF, next cycle r0 read addr 5 -> r0_gnt=1 both cycles; mem_we=1 on the first cycle only; r0_rvalid=1 with r0_rdata=0xDEADBEEF one cycle after the read; r1 outputs stay 0.
2. Both request reads every cycle, no lock, r0 addr 1, r1 addr 2 -> grants alternate r0,r1,r0,r1 starting with r0; each rvalid follows its grant by exactly 1 cycle.
3. r1 lock burst of 4 reads (lock=1 on the first 3, lock=0 on the 4th) while r0 requests continuously -> r1 granted 4 consecutive cycles, then r0 granted; r0_gnt=0 throughout the burst.
4. r1 holds lock=1 and req=1 indefinitely, MAX_BURST=8, r0 requesting -> r1 granted exactly 8 cycles, then r0 granted 1 cycle, then r1 relocks.
5. In LOCK0, r0 drops req for a cycle while r1 requests -> no grant, mem_we=0, mem_a=0 that cycle; r1 granted the following cycle.
6. Assert rst in the same cycle as an r0 read grant mid-burst -> next cycle r0_rvalid=0, r0_rdata=0, state IDLE; with both requesting afterwards r0 is granted first.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its memory wrapper.
package dmem_arb_pkg;

  // IDLE: free arbitration; LOCKn: requester n owns the memory for a burst.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Requester indices: 0 is the core LSU, 1 is the DMA/debug loader.
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  // Default memory geometry, shared with the memory wrapper.
  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational round-robin pick between two requesters, honouring lock ownership.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  arb_state_t state,
  output logic [1:0] gnt
);

  // One-hot grant: ties go to the requester that did not win last; a lock excludes the other side.
  always_comb begin
    gnt = 2'b00;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          gnt = last ? 2'b01 : 2'b10;
        end else begin
          gnt = req;
        end
      end
      LOCK0:   gnt = {1'b0, req[REQ0]};
      LOCK1:   gnt = {req[REQ1], 1'b0};
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer in front of the single-port data memory.
// One access per cycle, round-robin on ties, capped locked bursts, registered read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  arb_state_t       state_r;
  logic             last_r;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [1:0]       req_s;
  logic [1:0]       gnt_s;
  logic             win_lock_s;

  assign req_s     = {r1_req, r0_req};
  assign cnt_inc_s = burst_cnt_r + CNT_ONE;
  assign r0_gnt    = gnt_s[REQ0];
  assign r1_gnt    = gnt_s[REQ1];

  dmem_arb_pick u_pick (
    .req   (req_s),
    .last  (last_r),
    .state (state_r),
    .gnt   (gnt_s)
  );

  // Route the winner's access to the memory; drive all-zero when nobody is granted.
  always_comb begin
    mem_a      = {ADDR_W{1'b0}};
    mem_wd     = {DATA_W{1'b0}};
    mem_we     = 1'b0;
    win_lock_s = 1'b0;
    if (gnt_s[REQ1]) begin
      mem_a      = r1_addr;
      mem_wd     = r1_wdata;
      mem_we     = r1_we;
      win_lock_s = r1_lock;
    end else if (gnt_s[REQ0]) begin
      mem_a      = r0_addr;
      mem_wd     = r0_wdata;
      mem_we     = r0_we;
      win_lock_s = r0_lock;
    end else begin
      mem_a      = {ADDR_W{1'b0}};
      mem_wd     = {DATA_W{1'b0}};
      mem_we     = 1'b0;
      win_lock_s = 1'b0;
    end
  end

  // Capture read data at the grant edge; rvalid is a one-cycle pulse, rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_rvalid <= 1'b0;
      r0_rdata  <= {DATA_W{1'b0}};
      r1_rvalid <= 1'b0;
      r1_rdata  <= {DATA_W{1'b0}};
    end else begin
      r0_rvalid <= gnt_s[REQ0] & ~r0_we;
      r1_rvalid <= gnt_s[REQ1] & ~r1_we;
      if (gnt_s[REQ0] && !r0_we) begin
        r0_rdata <= mem_rd;
      end else begin
        r0_rdata <= r0_rdata;
      end
      if (gnt_s[REQ1] && !r1_we) begin
        r1_rdata <= mem_rd;
      end else begin
        r1_rdata <= r1_rdata;
      end
    end
  end

  // Arbitration FSM: tracks round-robin history, lock ownership and the burst length cap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      burst_cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s != 2'b00) begin
            last_r <= gnt_s[REQ1];
            if (win_lock_s && (MAX_BURST > 1)) begin
              state_r     <= gnt_s[REQ1] ? LOCK1 : LOCK0;
              burst_cnt_r <= CNT_ONE;
            end else begin
              state_r     <= IDLE;
              burst_cnt_r <= CNT_ZERO;
            end
          end else begin
            state_r     <= IDLE;
            burst_cnt_r <= CNT_ZERO;
          end
        end
        LOCK0: begin
          // The owner stays "last" so a waiting r1 wins right after release.
          last_r <= 1'b0;
          if (gnt_s[REQ0] && r0_lock && (cnt_inc_s != CNT_MAX)) begin
            state_r     <= LOCK0;
            burst_cnt_r <= cnt_inc_s;
          end else begin
            state_r     <= IDLE;
            burst_cnt_r <= CNT_ZERO;
          end
        end
        LOCK1: begin
          last_r <= 1'b1;
          if (gnt_s[REQ1] && r1_lock && (cnt_inc_s != CNT_MAX)) begin
            state_r     <= LOCK1;
            burst_cnt_r <= cnt_inc_s;
          end else begin
            state_r     <= IDLE;
            burst_cnt_r <= CNT_ZERO;
          end
        end
        default: begin
          state_r     <= IDLE;
          last_r      <= 1'b1;
          burst_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule
